sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_array.sv | 32 +++
 rtl/sram_ctrl.sv | 155 +++++++++++++++
 tb/tb_sram_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM state, read-latency limits and parity sizing for sram_ctrl
// Per-byte even parity is enabled by defining SRAM_PARITY_EN.
package sram_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

`ifdef SRAM_PARITY_EN
  localparam int PAR_PER_BYTE = 1;
`else
  localparam int PAR_PER_BYTE = 0;
`endif

  // Number of parity bits stored alongside a DW-bit data word.
  function automatic int par_width(input int dw);
    return (dw / 8) * PAR_PER_BYTE;
  endfunction

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - single-port storage with per-lane write enables and a registered read
// Lane width is W/NB, so parity bits (SRAM_PARITY_EN) travel inside each lane.
module sram_array #(
  parameter int W  = 32,
  parameter int AW = 16,
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [NB-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  localparam int LW = W / NB;

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q, rdata_d;

  always_comb rdata_d = mem[addr];

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    for (int b = 0; b < NB; b++) begin
      if (we && be[b]) mem[addr][b*LW +: LW] <= wdata[b*LW +: LW];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - SRAM controller: byte-masked writes, pipelined reads, zero-fill sequencer
// Defining SRAM_PARITY_EN adds per-byte even parity storage and checking on rsp_err.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  input  logic            init_start,
  output logic            init_done
);

  localparam int NB  = DW / 8;
  localparam int LW  = 8 + PAR_PER_BYTE;
  localparam int W   = DW + par_width(DW);
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            init_done_q, init_done_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic            arr_we;
  logic [NB-1:0]   arr_be;
  logic [AW-1:0]   arr_addr;
  logic [W-1:0]    arr_wdata, arr_rdata, enc_wdata, tail;
  logic [DW-1:0]   tail_data;
  logic            tail_err;
  logic            rd_acc;

  assign req_ready = (state_q == ST_IDLE) && !init_start;
  assign rd_acc    = req_ready && req_valid && !req_we;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = 1'b0;
    arr_we      = 1'b0;
    arr_be      = req_be;
    arr_addr    = req_addr;
    arr_wdata   = enc_wdata;
    case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d   = ST_CLR;
          clr_cnt_d = '0;
        end else if (req_valid && req_we) begin
          arr_we = 1'b1;
        end
      end
      ST_CLR: begin
        arr_we    = 1'b1;
        arr_be    = '1;
        arr_addr  = clr_cnt_q;
        arr_wdata = '0;
        if (clr_cnt_q == '1) begin
          state_d     = ST_IDLE;
          clr_cnt_d   = '0;
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lanes are {parity, byte} when parity is enabled; all-zero lanes already carry even parity.
  always_comb begin
    enc_wdata = '0;
    tail_data = '0;
    tail_err  = 1'b0;
    for (int b = 0; b < NB; b++) begin
      enc_wdata[b*LW +: 8] = req_wdata[b*8 +: 8];
      tail_data[b*8 +: 8]  = tail[b*LW +: 8];
`ifdef SRAM_PARITY_EN
      enc_wdata[b*LW + 8]  = ^req_wdata[b*8 +: 8];
      tail_err             = tail_err | (^tail[b*LW +: LW]);
`endif
    end
  end

  // The array read register is the first latency stage; LAT-1 more stages precede the output.
  if (LAT == 1) begin : g_lat1
    assign tail = arr_rdata;
  end else begin : g_latn
    logic [W-1:0] dat_q [LAT-1];
    logic [W-1:0] dat_d [LAT-1];
    always_comb begin
      dat_d[0] = arr_rdata;
      for (int i = 1; i < LAT - 1; i++) dat_d[i] = dat_q[i-1];
    end
    always_ff @(posedge clk) dat_q <= dat_d;
    assign tail = dat_q[LAT-2];
  end

  always_comb begin
    vld_d       = vld_q << 1;
    vld_d[0]    = rd_acc;
    rsp_valid_d = vld_q[LAT-1];
    rsp_rdata_d = rsp_valid_d ? tail_data : rsp_rdata_q;
    rsp_err_d   = rsp_valid_d & tail_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      vld_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      vld_q       <= vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  sram_array #(.W(W), .AW(AW), .NB(NB)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl (DW=32, AW=6, RD_LAT=3)
// Honours SRAM_PARITY_EN for the expected rsp_err after a stored-bit flip.
module tb_sram_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int LAT   = 3;
  localparam int DEPTH = 64;
`ifdef SRAM_PARITY_EN
  localparam logic PERR = 1'b1;
`else
  localparam logic PERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          init_start, init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.DW(DW), .AW(AW), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_start (init_start),
    .init_done  (init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
    bit          err;
  } rsp_t;

  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_pbad [DEPTH];
  rsp_t        rq[$];
  int          cyc = 0;
  int          m_clr_end = 0;
  bit          m_busy = 0, m_done = 0, m_vld = 0, m_err = 0, m_dknown = 0;
  logic [31:0] m_dat = 0, m_last = 0;
  bit          m_last_known = 1;
  bit          chk_en = 0;

  initial for (int a = 0; a < DEPTH; a++) begin
    m_mem[a] = 0; m_known[a] = 0; m_pbad[a] = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_vld = 0; m_err = 0;
      m_last = 0; m_last_known = 1;
      rq.delete();
    end else begin
      cyc++;
      m_done = 0; m_vld = 0; m_err = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        m_vld = 1; m_dat = rq[0].data; m_dknown = rq[0].known;
        m_err = rq[0].known && rq[0].err;
        m_last = m_dat; m_last_known = m_dknown;
        void'(rq.pop_front());
      end
      if (m_busy) begin
        if (cyc == m_clr_end) begin
          m_busy = 0; m_done = 1;
          for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = 0; m_known[a] = 1; m_pbad[a] = 0;
          end
        end
      end else if (init_start) begin
        m_busy = 1; m_clr_end = cyc + DEPTH;
        for (int a = 0; a < DEPTH; a++) m_known[a] = 0;
      end else if (req_valid) begin
        if (req_we) begin
          for (int b = 0; b < 4; b++)
            if (req_be[b]) m_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          if (req_be == 4'hF) m_known[req_addr] = 1;
          if (req_be[0]) m_pbad[req_addr] = 0;
        end else begin
          rq.push_back('{due: cyc + LAT, data: m_mem[req_addr],
                         known: m_known[req_addr], err: m_pbad[req_addr]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy && !init_start));
      chk("init_done", 32'(init_done), 32'(m_done));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
      if (m_vld && m_dknown) begin
        chk("rsp_rdata", rsp_rdata, m_dat);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end else if (!m_vld) begin
        chk("rsp_err_idle", 32'(rsp_err), 32'd0);
        if (m_last_known) chk("rsp_rdata_hold", rsp_rdata, m_last);
      end
    end
  end

  // ---------------- observers ----------------
  int          tcyc = 0;
  int          done_cnt = 0;
  logic [31:0] got_d[$];
  int          got_c[$];

  always @(posedge clk) tcyc++;
  always @(negedge clk) begin
    if (init_done) done_cnt++;
    if (rst_n && rsp_valid) begin
      got_d.push_back(rsp_rdata);
      got_c.push_back(tcyc);
    end
  end

  // ---------------- stimulus helpers (entered #1 after a rising edge) ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 0; req_we = 0;
  endtask

  task automatic read_lit(input string name, input logic [AW-1:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
    int lat;
    bit seen;
    req_valid = 1; req_we = 0; req_addr = a;
    @(posedge clk); #1;
    req_valid = 0;
    lat = -1; seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1; lat = i - 1;
        chk({name, "_data"}, rsp_rdata, exp_d);
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_e));
      end
    end
    chk({name, "_latency"}, lat, LAT);
    @(posedge clk); #1;
  endtask

  task automatic run_clear(input string name, input bit with_req);
    int low;
    init_start = 1;
    if (with_req) begin req_valid = 1; req_we = 0; req_addr = 6'd5; end
    #1 chk({name, "_ready_vs_init"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    init_start = 0; req_valid = 0;
    low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) break;
      low++;
    end
    chk({name, "_ready_low_cycles"}, low, DEPTH);
    chk({name, "_done_pulse"}, 32'(init_done), 32'd1);
    @(posedge clk); #1;
    chk({name, "_done_drop"}, 32'(init_done), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rdy_hi;
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    req_be = 0; init_start = 0;
    repeat (2) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_init_done", 32'(init_done), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    run_clear("clr1", 1'b1);
    chk("clr1_done_count", done_cnt, 1);
    for (int a = 0; a < DEPTH; a++) begin
      req_valid = 1; req_we = 0; req_addr = a[AW-1:0];
      @(posedge clk); #1;
    end
    req_valid = 0;
    repeat (LAT + 2) @(posedge clk); #1;

    do_write(6'h10, 32'hDEADBEEF, 4'hF);
    read_lit("rd_deadbeef", 6'h10, 32'hDEADBEEF, 1'b0);

    do_write(6'h20, 32'hFFFFFFFF, 4'hF);
    do_write(6'h20, 32'h11223344, 4'h5);
    read_lit("rd_bytemask", 6'h20, 32'hFF22FF44, 1'b0);

    for (int i = 1; i <= 8; i++) do_write(i[AW-1:0], 32'hA0000000 + i, 4'hF);
    got_d.delete(); got_c.delete();
    rdy_hi = 0;
    for (int i = 1; i <= 8; i++) begin
      req_valid = 1; req_we = 0; req_addr = i[AW-1:0];
      if (req_ready) rdy_hi++;
      @(posedge clk); #1;
    end
    req_valid = 0;
    repeat (LAT + 3) @(posedge clk); #1;
    chk("burst_ready", rdy_hi, 8);
    chk("burst_count", got_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_d.size()) begin
        chk("burst_data", got_d[i], 32'hA0000001 + i);
        if (i > 0) chk("burst_gap", got_c[i] - got_c[i-1], 1);
      end
    end

    got_d.delete(); got_c.delete();
    req_valid = 1; req_we = 0; req_addr = 6'h10;
    @(posedge clk); #1;
    req_valid = 0;
    run_clear("clr2", 1'b0);
    chk("inflight_count", got_d.size(), 1);
    if (got_d.size() > 0) chk("inflight_data", got_d[0], 32'hDEADBEEF);
    chk("clr2_done_count", done_cnt, 2);
    read_lit("rd_after_clear", 6'h10, 32'h0, 1'b0);

    init_start = 1;
    @(posedge clk); #1;
    init_start = 0;
    repeat (5) @(posedge clk); #1;
    rst_n = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    chk("rst_mid_clear_ready", 32'(req_ready), 32'd1);
    repeat (DEPTH + 10) @(posedge clk); #1;
    chk("rst_mid_clear_no_done", done_cnt, 2);

    do_write(6'h30, 32'hCAFEF00D, 4'hF);
    read_lit("rd_cafe", 6'h30, 32'hCAFEF00D, 1'b0);
    dut.u_array.mem[6'h30][0] = ~dut.u_array.mem[6'h30][0];
    m_mem[6'h30][0] = ~m_mem[6'h30][0];
    m_pbad[6'h30] = PERR;
    read_lit("rd_flipped", 6'h30, 32'hCAFEF00C, PERR);
    do_write(6'h30, 32'h0000000D, 4'h1);
    read_lit("rd_repaired", 6'h30, 32'hCAFEF00D, 1'b0);

    repeat (4) @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
